// File: rtl/addsub_pkg.sv
// Shared KPG (kill/propagate/generate) encoding and merge semantics for the
// integer-adder functional unit.
package addsub_pkg;

  typedef logic [1:0] kpg_t;

  localparam kpg_t KPG_KILL = 2'b00;
  localparam kpg_t KPG_PROP = 2'b10;
  localparam kpg_t KPG_GEN  = 2'b11;

  // Per-bit pair: upper bit is "not kill" (a|b), lower bit is "generate" (a&b).
  function automatic kpg_t kpg_pair(input logic a, input logic b);
    return {a | b, a & b};
  endfunction

  // A propagating group defers to the lower-order group; K or G stands alone.
  function automatic kpg_t kpg_combine(input kpg_t cur, input kpg_t prev);
    return (cur == KPG_PROP) ? prev : cur;
  endfunction

endpackage

// File: rtl/prefix_cell.sv
// Combinational KPG merge of one prefix node: the current (higher) group
// with the previous (lower) group.
module prefix_cell
  import addsub_pkg::*;
(
  input  kpg_t cur,
  input  kpg_t prev,
  output kpg_t grp
);

  assign grp = kpg_combine(cur, prev);

endmodule

// File: rtl/pipe_prefix_addsub.sv
// Fully pipelined Kogge-Stone adder/subtractor: one operand register stage,
// one register per prefix level, outputs formed in the last level's register.
module pipe_prefix_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS  = $clog2(WIDTH);
  localparam int LATENCY = LEVELS + 1;

  logic               adv;
  logic [LATENCY-1:0] vld;

  logic [WIDTH-1:0]   b_c;
  logic [WIDTH-1:0]   p0;
  kpg_t [WIDTH-1:0]   kpg0;

  kpg_t [WIDTH-1:0]   kpg_q   [LEVELS];
  logic [WIDTH-1:0]   p_q     [LEVELS];
  logic               msb_a_q [LEVELS];
  logic               msb_b_q [LEVELS];
  logic               sub_q   [LEVELS];
  logic [TAG_W-1:0]   tag_q   [LEVELS];

  kpg_t [WIDTH-1:0]   lvl_d   [1:LEVELS];

  logic [WIDTH:0]     carry;
  logic [WIDTH-1:0]   sum_d;
  logic               ovf_d;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv & ~flush;
  assign out_valid = vld[LATENCY-1];

  // Operand conditioning; the carry-in is folded into bit 0 so every
  // prefix group resolves to K or G after the last level.
  always_comb begin
    b_c  = in_sub ? ~in_b : in_b;
    p0   = in_a ^ b_c;
    kpg0 = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      kpg0[i] = kpg_pair(in_a[i], b_c[i]);
    end
    kpg0[0] = kpg_combine(kpg0[0], in_sub ? KPG_GEN : KPG_KILL);
  end

  genvar k, i;
  generate
    for (k = 1; k <= LEVELS; k++) begin : g_level
      for (i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= (1 << (k - 1))) begin : g_cell
          prefix_cell u_cell (
            .cur  (kpg_q[k-1][i]),
            .prev (kpg_q[k-1][i - (1 << (k - 1))]),
            .grp  (lvl_d[k][i])
          );
        end else begin : g_pass
          assign lvl_d[k][i] = kpg_q[k-1][i];
        end
      end
    end
  endgenerate

  always_comb begin
    carry    = '0;
    carry[0] = sub_q[LEVELS-1];
    for (int unsigned j = 0; j < WIDTH; j++) begin
      carry[j+1] = (lvl_d[LEVELS][j] == KPG_GEN);
    end
    sum_d = p_q[LEVELS-1] ^ carry[WIDTH-1:0];
    // Same as carry[WIDTH]^carry[WIDTH-1]: like-signed operands, unlike-signed sum.
    ovf_d = (msb_a_q[LEVELS-1] ~^ msb_b_q[LEVELS-1]) &
            (sum_d[WIDTH-1] ^ msb_a_q[LEVELS-1]);
  end

  // Data stages carry no reset; validity lives only in vld.
  always_ff @(posedge clk) begin
    if (adv) begin
      kpg_q[0]   <= kpg0;
      p_q[0]     <= p0;
      msb_a_q[0] <= in_a[WIDTH-1];
      msb_b_q[0] <= b_c[WIDTH-1];
      sub_q[0]   <= in_sub;
      tag_q[0]   <= in_tag;
      for (int unsigned s = 1; s < LEVELS; s++) begin
        kpg_q[s]   <= lvl_d[s];
        p_q[s]     <= p_q[s-1];
        msb_a_q[s] <= msb_a_q[s-1];
        msb_b_q[s] <= msb_b_q[s-1];
        sub_q[s]   <= sub_q[s-1];
        tag_q[s]   <= tag_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
      out_tag  <= '0;
    end else if (flush) begin
      vld <= '0;
    end else if (adv) begin
      vld      <= {vld[LATENCY-2:0], in_valid};
      out_sum  <= sum_d;
      out_cout <= carry[WIDTH];
      out_ovf  <= ovf_d;
      out_zero <= ~|sum_d;
      out_tag  <= tag_q[LEVELS-1];
    end
  end

endmodule

// File: tb/tb_pipe_prefix_addsub.sv
// Scoreboard bench for pipe_prefix_addsub: 32-bit and 8-bit instances driven
// with directed vectors whose expected results are worked out by hand.
module tb_pipe_prefix_addsub;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
    bit          lat;
    int          exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        flush32, flush8;
  logic        v32, r32, sub32, o32_valid, o32_ready, o32_cout, o32_ovf, o32_zero;
  logic [31:0] a32, b32, o32_sum;
  logic [3:0]  t32, o32_tag;
  logic        v8, r8, sub8, o8_valid, o8_ready, o8_cout, o8_ovf, o8_zero;
  logic [7:0]  a8, b8, o8_sum;
  logic [3:0]  t8, o8_tag;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q32[$];
  exp_t q8[$];

  // Back-to-back batch: a, b, sub, expected sum, cout, ovf, zero (tags 0..9)
  logic [31:0] ba [10] = '{32'h00000001, 32'h7FFFFFFF, 32'h0000000A, 32'h00000000, 32'h12345678,
                           32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000064, 32'hAAAAAAAA};
  logic [31:0] bb [10] = '{32'h00000002, 32'h00000001, 32'h0000000A, 32'h00000001, 32'h11111111,
                           32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000007, 32'h55555555};
  logic        bs [10] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
  logic [31:0] bx [10] = '{32'h00000003, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h23456789,
                           32'hFFFFFFFE, 32'h00000000, 32'h80000000, 32'h0000005D, 32'hFFFFFFFF};
  logic        bc [10] = '{0, 0, 1, 0, 0, 1, 1, 0, 1, 0};
  logic        bo [10] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0};
  logic        bz [10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

  pipe_prefix_addsub #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .flush(flush32), .in_valid(v32), .in_ready(r32),
    .in_a(a32), .in_b(b32), .in_sub(sub32), .in_tag(t32),
    .out_valid(o32_valid), .out_ready(o32_ready), .out_sum(o32_sum),
    .out_cout(o32_cout), .out_ovf(o32_ovf), .out_zero(o32_zero), .out_tag(o32_tag)
  );

  pipe_prefix_addsub #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .flush(flush8), .in_valid(v8), .in_ready(r8),
    .in_a(a8), .in_b(b8), .in_sub(sub8), .in_tag(t8),
    .out_valid(o8_valid), .out_ready(o8_ready), .out_sum(o8_sum),
    .out_cout(o8_cout), .out_ovf(o8_ovf), .out_zero(o8_zero), .out_tag(o8_tag)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic compare(input string name, input exp_t e, input logic [31:0] sum,
                         input logic cout, input logic ovf, input logic zero, input logic [3:0] tag);
    checks++;
    if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf || zero !== e.zero || tag !== e.tag) begin
      errors++;
      $display("FAIL %s: got sum=%h c=%b o=%b z=%b tag=%0d, required sum=%h c=%b o=%b z=%b tag=%0d",
               name, sum, cout, ovf, zero, tag, e.sum, e.cout, e.ovf, e.zero, e.tag);
    end
    if (e.lat) chk({name, "_latency"}, cyc, e.exp_cyc);
  endtask

  // Monitor: pops one expectation per output handshake; a flush kills the queue.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (o32_valid && o32_ready) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out32: got tag=%0d sum=%h, required no result", o32_tag, o32_sum);
        end else begin
          compare("result32", q32.pop_front(), o32_sum, o32_cout, o32_ovf, o32_zero, o32_tag);
        end
      end
      if (o8_valid && o8_ready) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out8: got tag=%0d sum=%h, required no result", o8_tag, o8_sum);
        end else begin
          compare("result8", q8.pop_front(), {24'h0, o8_sum}, o8_cout, o8_ovf, o8_zero, o8_tag);
        end
      end
      if (flush32) q32.delete();
    end
  end

  // Drives one op, holds it until accepted, pushes its expectation on acceptance.
  task automatic issue(input bit w8, input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [3:0] tag, input logic [31:0] es, input logic ec, input logic eo,
                       input logic ez, input bit lat);
    exp_t e;
    bit   done;
    e.sum = es; e.cout = ec; e.ovf = eo; e.zero = ez; e.tag = tag; e.lat = lat; e.exp_cyc = 0;
    done = 1'b0;
    if (w8) begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; t8 = tag; v8 = 1'b1;
    end else begin
      a32 = a; b32 = b; sub32 = sub; t32 = tag; v32 = 1'b1;
    end
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (w8 ? r8 : r32) begin
        e.exp_cyc = cyc + (w8 ? 4 : 6);
        if (w8) q8.push_back(e);
        else    q32.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (w8) v8 = 1'b0;
    else    v32 = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue_timeout: tag %0d got no in_ready, required acceptance within 60 cycles", tag);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", q32.size() + q8.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    flush32 = 1'b0; flush8 = 1'b0; o32_ready = 1'b1; o8_ready = 1'b1;
    a32 = 32'h11; b32 = 32'h22; sub32 = 1'b0; t32 = 4'd7; v32 = 1'b1;
    a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; t8 = 4'd7; v8 = 1'b1;

    // Reset with in_valid held high: nothing may be accepted.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; v32 = 1'b0; v8 = 1'b0;
    @(negedge clk);
    chk("rst_out_valid32", o32_valid, 0);
    chk("rst_out_sum32", o32_sum, 0);
    chk("rst_flags_tag32", {o32_cout, o32_ovf, o32_zero, o32_tag}, 0);
    chk("rst_in_ready32", r32, 1);
    chk("rst_out_valid8", o8_valid, 0);
    chk("rst_in_ready8", r8, 1);
    repeat (8) @(negedge clk);
    chk("rst_nothing_accepted", o32_valid, 0);
    @(posedge clk); #1;

    // Directed 32-bit boundaries, latency checked.
    issue(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 4'd5, 32'h00000000, 1, 0, 1, 1);
    drain();
    issue(0, 32'h80000000, 32'h00000001, 1'b1, 4'd2, 32'h7FFFFFFF, 1, 1, 0, 1);
    issue(0, 32'h00000003, 32'h00000005, 1'b1, 4'd3, 32'hFFFFFFFE, 0, 0, 0, 1);
    drain();

    // Ten back-to-back ops with out_ready low on cycles 7-10.
    fork
      begin
        for (int i = 0; i < 10; i++)
          issue(0, ba[i], bb[i], bs[i], 4'(i), bx[i], bc[i], bo[i], bz[i], 0);
      end
      begin
        repeat (7) @(posedge clk);
        #1 o32_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", r32, 0);
        end
        @(posedge clk);
        #1 o32_ready = 1'b1;
      end
    join
    drain();

    // Flush: tags 1..3 in flight, tag 4 presented with flush, tag 5 right after.
    issue(0, 32'h1, 32'h1, 1'b0, 4'd1, 32'h2, 0, 0, 0, 0);
    issue(0, 32'h2, 32'h2, 1'b0, 4'd2, 32'h4, 0, 0, 0, 0);
    issue(0, 32'h3, 32'h3, 1'b0, 4'd3, 32'h6, 0, 0, 0, 0);
    a32 = 32'h4; b32 = 32'h4; sub32 = 1'b0; t32 = 4'd4; v32 = 1'b1; flush32 = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", r32, 0);
    @(posedge clk);
    #1 flush32 = 1'b0; v32 = 1'b0;
    fork
      issue(0, 32'h5, 32'h6, 1'b0, 4'd5, 32'h0000000B, 0, 0, 0, 1);
      begin
        @(negedge clk);
        chk("post_flush_out_valid", o32_valid, 0);
      end
    join
    drain();

    // 8-bit instance.
    issue(1, 32'h7F, 32'h01, 1'b0, 4'd9, 32'h80, 0, 1, 0, 1);
    issue(1, 32'h00, 32'h00, 1'b1, 4'd10, 32'h00, 1, 0, 1, 1);
    issue(1, 32'h80, 32'h01, 1'b1, 4'd11, 32'h7F, 1, 1, 0, 1);
    drain();

    repeat (10) @(posedge clk);
    chk("final_queue_empty", q32.size() + q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
